control_sequencer: RTL

//  Parametrised successor to the combinational microinstruction decoder. Decodes the 16-bit

---
 rtl/control_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Brief   : Microinstruction decoder and microcode step counter with early end,
//           halt, and a device wait handshake with optional timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int STEP_BITS  = 3,
    parameter int MAX_STEP   = 7,
    parameter int DEV_IDX    = 6,
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          i_uinstr,
    input  logic                 i_flag_z,
    input  logic                 i_flag_c,
    input  logic                 i_flag_lt,
    input  logic                 i_dev_ready,
    input  logic                 i_halt,
    output logic [STEP_BITS-1:0] o_step,
    output logic                 o_eo_n,
    output logic [5:0]           o_alu_flags,
    output logic [7:0]           o_bus_out_en_n,
    output logic [7:0]           o_bus_in_en_n,
    output logic                 o_rt,
    output logic                 o_pp,
    output logic                 o_jump,
    output logic                 o_instr_done,
    output logic                 o_stalled,
    output logic                 o_timeout
);

    localparam logic [STEP_BITS-1:0] c_MAX_STEP   = MAX_STEP[STEP_BITS-1:0];
    localparam logic [STEP_BITS-1:0] c_STEP_ONE   = {{(STEP_BITS-1){1'b0}}, 1'b1};
    localparam logic [2:0]           c_DEV_IDX    = DEV_IDX[2:0];
    localparam logic [WAIT_BITS-1:0] c_WAIT_LIMIT = WAIT_LIMIT[WAIT_BITS-1:0];
    localparam logic [WAIT_BITS-1:0] c_WAIT_ONE   = {{(WAIT_BITS-1){1'b0}}, 1'b1};
    localparam logic                 c_TIMEOUT_EN = (WAIT_LIMIT != 0);

    logic [STEP_BITS-1:0] r_step;
    logic [WAIT_BITS-1:0] r_wait_cnt;
    logic                 r_timeout;

    logic       w_eo_n;
    logic [2:0] w_out_sel;
    logic [2:0] w_in_sel;
    logic       w_end;
    logic       w_dev_access;
    logic       w_force;
    logic       w_stall;
    logic       w_active;
    logic       w_rt;
    logic       w_last;
    logic       w_unused;

    assign w_eo_n    = i_uinstr[15];
    assign w_out_sel = i_uinstr[14:12];
    assign w_in_sel  = i_uinstr[8:6];
    assign w_end     = i_uinstr[1];
    assign w_unused  = i_uinstr[0];

    assign w_dev_access = (w_eo_n && (w_out_sel == c_DEV_IDX)) || (w_in_sel == c_DEV_IDX);
    assign w_force      = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LIMIT);
    assign w_stall      = w_dev_access && !i_dev_ready && !w_force;
    assign w_active     = !reset && !i_halt && !w_stall;
    assign w_rt         = w_active && w_eo_n && i_uinstr[11];
    assign w_last       = w_end || w_rt || (r_step == c_MAX_STEP);

    // Sources stay driven while held so the bus value is stable across a stall.
    always_comb begin
        o_bus_out_en_n = 8'hFF;
        o_bus_in_en_n  = 8'hFF;
        if (!reset && w_eo_n) begin
            o_bus_out_en_n = ~(8'h01 << w_out_sel);
        end
        if (w_active && (w_in_sel != 3'd0)) begin
            o_bus_in_en_n = ~(8'h01 << w_in_sel);
        end
    end

    assign o_step       = r_step;
    assign o_eo_n       = w_eo_n;
    assign o_alu_flags  = i_uinstr[14:9];
    assign o_rt         = w_rt;
    assign o_pp         = w_active && w_eo_n && i_uinstr[10];
    assign o_jump       = w_active && ((i_uinstr[5] && i_flag_c) ||
                                       (i_uinstr[4] && i_flag_z) ||
                                       (i_uinstr[3] && !i_flag_z && !i_flag_lt) ||
                                       (i_uinstr[2] && i_flag_lt));
    assign o_instr_done = w_active && w_last;
    assign o_stalled    = !reset && w_stall;
    assign o_timeout    = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
        end else if (!i_halt && !w_stall) begin
            r_step <= w_last ? '0 : r_step + c_STEP_ONE;
        end
    end

    // Halt freezes an in-progress wait so the count resumes where it left off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!w_stall) begin
            r_wait_cnt <= '0;
        end else if (!i_halt && (r_wait_cnt != c_WAIT_LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_force && w_dev_access && !i_dev_ready && !i_halt) begin
            r_timeout <= 1'b1;
        end
    end

endmodule

`default_nettype wire
